// File: rtl/univ_shreg_pkg.sv
// Shared types for the universal shift register: operation modes and the
// sequencer FSM states. The optional parity output is controlled by the
// UNIV_SHREG_PARITY_EN macro in the top module.
package univ_shreg_pkg;

    // Operation select. 3'b111 is reserved and behaves like HOLD.
    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROTL = 3'b100,
        MODE_ROTR = 3'b101,
        MODE_ASHR = 3'b110,
        MODE_RSVD = 3'b111
    } mode_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // True for modes that can be repeated as a multi-step sequence.
    function automatic logic is_seq_mode(input logic [2:0] m);
        logic r;
        case (m)
            MODE_SHL, MODE_SHR, MODE_ROTL, MODE_ROTR, MODE_ASHR: r = 1'b1;
            default:                                             r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/univ_shreg_step.sv
// One single-bit step of the shift/rotate operations. Purely combinational;
// shared by legacy single-step operation and every RUN step of a sequence.
// LOAD is not handled here (it needs parallel data); it passes the value through.
module univ_shreg_step
    import univ_shreg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic [2:0]       i_mode,
    input  logic             i_serial_l,
    input  logic             i_serial_r,
    output logic [WIDTH-1:0] o_next
);

    // Next value for a single step of the selected mode.
    always_comb begin
        o_next = i_value;
        case (i_mode)
            MODE_SHL:  o_next = {i_value[WIDTH-2:0], i_serial_r};
            MODE_SHR:  o_next = {i_serial_l, i_value[WIDTH-1:1]};
            MODE_ROTL: o_next = {i_value[WIDTH-2:0], i_value[WIDTH-1]};
            MODE_ROTR: o_next = {i_value[0], i_value[WIDTH-1:1]};
            MODE_ASHR: o_next = {i_value[WIDTH-1], i_value[WIDTH-1:1]};
            default:   o_next = i_value;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg_seq.sv
// Universal shift register with a sequenced multi-bit shift engine.
// IDLE executes the live mode once per enabled edge; start with a shift-type
// mode and non-zero amount runs RUN for min(shift_amt, WIDTH) enabled edges,
// then pulses done for one enabled cycle.
// Optional: define UNIV_SHREG_PARITY_EN to add a registered parity_out port.
module univ_shift_reg_seq
    import univ_shreg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] shift_amt,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             serial_in_r,
    input  logic             serial_in_l,
    output logic [WIDTH-1:0] parallel_out,
    output logic             serial_out_l,
    output logic             serial_out_r,
    output logic             busy,
    output logic             done
`ifdef UNIV_SHREG_PARITY_EN
    ,
    output logic             parity_out
`endif
);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_mode;
    logic [WIDTH-1:0] r_reg;
    logic             r_busy;
    logic             r_done;

    logic [2:0]       w_step_mode;
    logic [WIDTH-1:0] w_step_val;
    logic [WIDTH-1:0] w_next_val;
    logic [CNT_W-1:0] w_amt_clamped;
    logic             w_seq_ok;
    logic             w_seq_start;
    logic             w_reg_we;

    // In RUN the latched mode drives the step; otherwise the live mode does.
    assign w_step_mode = (r_state == ST_RUN) ? r_mode : mode;

    univ_shreg_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_value    (r_reg),
        .i_mode     (w_step_mode),
        .i_serial_l (serial_in_l),
        .i_serial_r (serial_in_r),
        .o_next     (w_step_val)
    );

    // LOAD only reaches the register outside RUN (RUN never latches LOAD).
    assign w_next_val = ((r_state != ST_RUN) && (mode == MODE_LOAD)) ? parallel_in : w_step_val;

    // Amounts beyond the register width are equivalent to a full-width sequence.
    assign w_amt_clamped = (shift_amt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : shift_amt;

    assign w_seq_ok    = is_seq_mode(mode) && (shift_amt != '0);
    assign w_seq_start = start && w_seq_ok;

    // The register is untouched on the edge that enters RUN and in DONE.
    assign w_reg_we = enable &&
                      (((r_state == ST_IDLE) && !w_seq_start) || (r_state == ST_RUN));

    // Data register update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_reg <= '0;
        end else if (w_reg_we) begin
            r_reg <= w_next_val;
        end
    end

    // Sequencer FSM with step counter and registered busy/done decodes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_mode  <= MODE_HOLD;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (enable) begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_seq_ok) begin
                            r_state <= ST_RUN;
                            r_mode  <= mode;
                            r_cnt   <= w_amt_clamped;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end else begin
                            // Degenerate request: the op already ran this edge.
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef UNIV_SHREG_PARITY_EN
    logic r_parity;

    // Parity tracks the register, updated on the same edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_parity <= 1'b0;
        end else if (w_reg_we) begin
            r_parity <= ^w_next_val;
        end
    end

    assign parity_out = r_parity;
`endif

    assign parallel_out = r_reg;
    assign serial_out_l = r_reg[WIDTH-1];
    assign serial_out_r = r_reg[0];
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_univ_shift_reg_seq.sv
// Self-checking bench for univ_shift_reg_seq (WIDTH=8): directed scenarios,
// a done/enable interaction check and randomized sequences against a
// bit-level reference model, with expected results queued at stimulus time.
module tb_univ_shift_reg_seq;
    import univ_shreg_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk         = 1'b0;
    logic             reset_n     = 1'b0;
    logic             enable      = 1'b0;
    logic [2:0]       mode        = 3'b000;
    logic             start       = 1'b0;
    logic [CNT_W-1:0] shift_amt   = '0;
    logic [WIDTH-1:0] parallel_in = '0;
    logic             serial_in_r = 1'b0;
    logic             serial_in_l = 1'b0;
    logic [WIDTH-1:0] parallel_out;
    logic             serial_out_l;
    logic             serial_out_r;
    logic             busy;
    logic             done;
`ifdef UNIV_SHREG_PARITY_EN
    logic             parity_out;
`endif

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] exp_q[$];

    univ_shift_reg_seq #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .mode         (mode),
        .start        (start),
        .shift_amt    (shift_amt),
        .parallel_in  (parallel_in),
        .serial_in_r  (serial_in_r),
        .serial_in_l  (serial_in_l),
        .parallel_out (parallel_out),
        .serial_out_l (serial_out_l),
        .serial_out_r (serial_out_r),
        .busy         (busy),
        .done         (done)
`ifdef UNIV_SHREG_PARITY_EN
        ,
        .parity_out   (parity_out)
`endif
    );

    // Clock and reset block
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: one step of a shift-type mode.
    function automatic logic [WIDTH-1:0] model_step(input logic [WIDTH-1:0] v, input logic [2:0] m,
                                                   input logic sl, input logic sr);
        logic [WIDTH-1:0] n;
        n = v;
        if (m == 3'b010)      n = (v << 1) | {{(WIDTH-1){1'b0}}, sr};
        else if (m == 3'b011) n = (v >> 1) | {sl, {(WIDTH-1){1'b0}}};
        else if (m == 3'b100) n = (v << 1) | {{(WIDTH-1){1'b0}}, v[WIDTH-1]};
        else if (m == 3'b101) n = (v >> 1) | {v[0], {(WIDTH-1){1'b0}}};
        else if (m == 3'b110) n = (v >> 1) | {v[WIDTH-1], {(WIDTH-1){1'b0}}};
        return n;
    endfunction

    // Driver: single-cycle load, then back to HOLD.
    task automatic load_val(input logic [WIDTH-1:0] v);
        enable      = 1'b1;
        start       = 1'b0;
        mode        = MODE_LOAD;
        parallel_in = v;
        tick();
        mode        = MODE_HOLD;
    endtask

    // Driver + monitor: issue a start, then watch busy/done until the done
    // pulse has ended. The result is checked against the queue head when done rises.
    // gap_at >= 0 drops enable for two edges starting at that observed cycle.
    task automatic run_seq(input logic [2:0] m, input logic [CNT_W-1:0] amt, input int gap_at,
                           output int busy_cycles, output int done_cycles);
        logic [WIDTH-1:0] exp_v;
        bit finished;
        busy_cycles = 0;
        done_cycles = 0;
        finished    = 1'b0;
        enable    = 1'b1;
        start     = 1'b1;
        mode      = m;
        shift_amt = amt;
        tick();
        start     = 1'b0;
        mode      = MODE_HOLD;
        shift_amt = '0;
        for (int c = 0; c < 40; c++) begin
            if (done) begin
                if (done_cycles == 0) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL seq_result: done with empty queue, got %h", parallel_out);
                    end else begin
                        exp_v = exp_q.pop_front();
                        if (parallel_out !== exp_v) begin
                            bad++;
                            $display("FAIL seq_result: got %h want %h", parallel_out, exp_v);
                        end
                    end
                end
                done_cycles++;
            end else if (done_cycles > 0) begin
                finished = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            if (gap_at >= 0 && c == gap_at)     enable = 1'b0;
            if (gap_at >= 0 && c == gap_at + 2) enable = 1'b1;
            tick();
        end
        enable = 1'b1;
        total++;
        if (!finished) begin
            bad++;
            $display("FAIL seq_timeout: done_cycles=%0d busy_cycles=%0d want completed pulse",
                     done_cycles, busy_cycles);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b1;
        tick();
        tick();
        total++;
        if (parallel_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: out=%h busy=%b done=%b want 00 0 0", parallel_out, busy, done);
        end
        reset_n = 1'b1;
        load_val(8'hA5);
        tick();
        total++;
        if (parallel_out !== 8'hA5 || serial_out_l !== 1'b1 || serial_out_r !== 1'b1) begin
            bad++;
            $display("FAIL load_a5: out=%h sl=%b sr=%b want a5 1 1", parallel_out, serial_out_l, serial_out_r);
        end
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL load_no_handshake: busy=%b done=%b want 0 0", busy, done);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (parallel_out !== 8'h00) begin
            bad++;
            $display("FAIL async_reset: got %h want 00", parallel_out);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_single_step();
        logic [2:0]       modes[7] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
        logic [WIDTH-1:0] exps[7]  = '{8'h96, 8'h2D, 8'h4B, 8'h2D, 8'h4B, 8'hCB, 8'h96};
        for (int i = 0; i < 7; i++) begin
            load_val(8'h96);
            serial_in_r = 1'b1;
            serial_in_l = 1'b0;
            mode        = modes[i];
            tick();
            mode        = MODE_HOLD;
            total++;
            if (parallel_out !== exps[i] || done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL single_step mode=%b: out=%h busy=%b done=%b want %h 0 0",
                         modes[i], parallel_out, busy, done, exps[i]);
            end
        end
        serial_in_r = 1'b0;
    endtask

    task automatic test_rotl();
        int b, d;
        load_val(8'h81);
        exp_q.push_back(8'h0C);
        run_seq(MODE_ROTL, 4'd3, -1, b, d);
        total++;
        if (b != 3 || d != 1) begin
            bad++;
            $display("FAIL rotl3_timing: busy=%0d done=%0d want 3 1", b, d);
        end
    endtask

    task automatic test_ashr_shr();
        int b, d;
        load_val(8'h80);
        exp_q.push_back(8'hF0);
        run_seq(MODE_ASHR, 4'd3, -1, b, d);
        total++;
        if (b != 3 || d != 1) begin
            bad++;
            $display("FAIL ashr3_timing: busy=%0d done=%0d want 3 1", b, d);
        end
        load_val(8'h00);
        serial_in_l = 1'b1;
        exp_q.push_back(8'hC0);
        run_seq(MODE_SHR, 4'd2, -1, b, d);
        serial_in_l = 1'b0;
        total++;
        if (b != 2 || d != 1) begin
            bad++;
            $display("FAIL shr2_timing: busy=%0d done=%0d want 2 1", b, d);
        end
    endtask

    task automatic test_enable_gap();
        int b, d;
        load_val(8'h12);
        exp_q.push_back(8'h21);
        run_seq(MODE_ROTR, 4'd4, 1, b, d);
        total++;
        if (b != 6 || d != 1) begin
            bad++;
            $display("FAIL rotr4_gap_timing: busy=%0d done=%0d want 6 1", b, d);
        end
    endtask

    task automatic test_done_hold();
        load_val(8'h01);
        enable    = 1'b1;
        start     = 1'b1;
        mode      = MODE_ROTL;
        shift_amt = 4'd1;
        tick();
        start     = 1'b0;
        mode      = MODE_HOLD;
        tick();
        enable    = 1'b0;
        tick();
        tick();
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || parallel_out !== 8'h02) begin
            bad++;
            $display("FAIL done_frozen: done=%b busy=%b out=%h want 1 0 02", done, busy, parallel_out);
        end
        enable = 1'b1;
        tick();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL done_release: done=%b want 0", done);
        end
    endtask

    task automatic test_amt_zero_clamp();
        int b, d;
        load_val(8'h5A);
        exp_q.push_back(8'h5A);
        run_seq(MODE_HOLD, 4'd0, -1, b, d);
        total++;
        if (b != 0 || d != 1) begin
            bad++;
            $display("FAIL amt0_timing: busy=%0d done=%0d want 0 1", b, d);
        end
        load_val(8'h3C);
        exp_q.push_back(8'h3C);
        run_seq(MODE_ROTL, 4'd12, -1, b, d);
        total++;
        if (b != 8 || d != 1) begin
            bad++;
            $display("FAIL clamp12_timing: busy=%0d done=%0d want 8 1", b, d);
        end
        load_val(8'h00);
        parallel_in = 8'h77;
        exp_q.push_back(8'h77);
        run_seq(MODE_LOAD, 4'd3, -1, b, d);
        total++;
        if (b != 0 || d != 1) begin
            bad++;
            $display("FAIL start_load_timing: busy=%0d done=%0d want 0 1", b, d);
        end
    endtask

    task automatic test_reset_mid_run();
        int b, d;
        bit seen;
        load_val(8'h01);
        serial_in_r = 1'b0;
        start       = 1'b1;
        mode        = MODE_SHL;
        shift_amt   = 4'd5;
        tick();
        start       = 1'b0;
        mode        = MODE_HOLD;
        tick();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL run_busy_before_reset: busy=%b want 1", busy);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || parallel_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid_run: busy=%b done=%b out=%h want 0 0 00", busy, done, parallel_out);
        end
        @(negedge clk);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) reset_n = 1'b1;
            if (done || busy) seen = 1'b1;
            tick();
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL aborted_no_done: saw busy/done after reset, want none");
        end
        load_val(8'h03);
        exp_q.push_back(8'h0C);
        run_seq(MODE_SHL, 4'd2, -1, b, d);
        total++;
        if (b != 2 || d != 1) begin
            bad++;
            $display("FAIL restart_timing: busy=%0d done=%0d want 2 1", b, d);
        end
    endtask

    task automatic test_back_to_back();
        int b, d, n;
        logic [WIDTH-1:0] v, e;
        logic [2:0] m;
        logic [CNT_W-1:0] amt;
        for (int i = 0; i < 10; i++) begin
            v           = WIDTH'($urandom_range(0, 255));
            m           = 3'($urandom_range(2, 6));
            amt         = CNT_W'($urandom_range(1, 11));
            serial_in_l = 1'($urandom_range(0, 1));
            serial_in_r = 1'($urandom_range(0, 1));
            load_val(v);
            n = (int'(amt) > WIDTH) ? WIDTH : int'(amt);
            e = v;
            for (int k = 0; k < n; k++) e = model_step(e, m, serial_in_l, serial_in_r);
            exp_q.push_back(e);
            run_seq(m, amt, -1, b, d);
            total++;
            if (b != n || d != 1) begin
                bad++;
                $display("FAIL rand_timing mode=%b amt=%0d: busy=%0d done=%0d want %0d 1", m, amt, b, d, n);
            end
        end
        serial_in_l = 1'b0;
        serial_in_r = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_rotl();
        test_ashr_shr();
        test_enable_gap();
        test_done_hold();
        test_amt_zero_clamp();
        test_reset_mid_run();
        test_back_to_back();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drained: %0d entries left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
